// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with press/release debounce and one-cycle key_valid per press.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scan #(
  parameter int N = 18,
  parameter int DB_N = 20,
  parameter int REPEAT_N = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;
  state_t state_q, state_d;
  logic [3:0] row_m_q, row_s_q;
  logic [N-1:0] dwell_q, dwell_d;
  logic [DB_N-1:0] db_q, db_d;
  logic [1:0] col_idx_q, col_idx_d, row_idx_q, row_idx_d, row_low;
  logic [3:0] col_q, col_d, key_code_q, key_code_d;
  logic key_valid_q, key_valid_d, key_down_q, key_down_d;
  logic sample, hit, row_hi, db_end, accept, done, rep_pulse;
  assign sample = state_q == SCAN && &dwell_q;
  assign hit = sample && row_s_q != 4'hF;
  assign row_hi = row_s_q[row_idx_q];
  assign db_end = &db_q;
  assign accept = state_q == DEBOUNCE && !row_hi && db_end;
  assign done = state_q == RELEASE && row_hi && db_end;
  assign row_low = !row_s_q[0] ? 2'd0 : !row_s_q[1] ? 2'd1 : !row_s_q[2] ? 2'd2 : 2'd3;
`ifdef KEYPAD_REPEAT_EN
  logic [REPEAT_N-1:0] rep_q, rep_d;
  assign rep_d = state_q == HELD ? rep_q + REPEAT_N'(1) : '0;
  assign rep_pulse = state_q == HELD && !row_hi && &rep_q;
  always_ff @(posedge clk) rep_q <= reset ? '0 : rep_d;
`else
  assign rep_pulse = REPEAT_N < 0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      row_m_q     <= 4'hF;
      row_s_q     <= 4'hF;
      dwell_q     <= '0;
      db_q        <= '0;
      col_idx_q   <= '0;
      row_idx_q   <= '0;
      col_q       <= 4'b1110;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_m_q     <= row;
      row_s_q     <= row_m_q;
      dwell_q     <= dwell_d;
      db_q        <= db_d;
      col_idx_q   <= col_idx_d;
      row_idx_q   <= row_idx_d;
      col_q       <= col_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN:     if (hit) state_d = DEBOUNCE;
      DEBOUNCE: state_d = row_hi ? SCAN : db_end ? HELD : DEBOUNCE;
      HELD:     if (row_hi) state_d = RELEASE;
      RELEASE:  state_d = !row_hi ? HELD : db_end ? SCAN : RELEASE;
      default:  state_d = SCAN;
    endcase
  end
  // dwell only runs in SCAN, so every return to SCAN restarts the column at zero
  always_comb begin
    dwell_d = state_q == SCAN ? dwell_q + N'(1) : '0;
    db_d = (state_q == DEBOUNCE && !row_hi) || (state_q == RELEASE && row_hi) ? db_q + DB_N'(1) : '0;
    col_idx_d = (sample && !hit) || done ? col_idx_q + 2'd1 : col_idx_q;
    row_idx_d = hit ? row_low : row_idx_q;
    col_d = ~(4'b0001 << col_idx_d);
    key_code_d = accept ? {row_idx_q, col_idx_q} : key_code_q;
    key_valid_d = accept || rep_pulse;
    key_down_d = accept ? 1'b1 : done ? 1'b0 : key_down_q;
  end
  assign col = col_q;
  assign key_code = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down = key_down_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized keypad presses checked against an edge-arithmetic model of scan/debounce timing.
module tb_keypad_scan;
  localparam int N = 2, DB_N = 3, REPEAT_N = 5;
  localparam int DW = 1 << N, DBW = 1 << DB_N, RW = 1 << REPEAT_N;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] row, col, key_code;
  logic key_valid, key_down;
  logic [15:0] keys = '0;
  int cyc = 0, checks = 0, errors = 0, scan_s = 0, scan_c = 0;
  logic [3:0] prev_code = '0;

  keypad_scan #(.N(N), .DB_N(DB_N), .REPEAT_N(REPEAT_N)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // passive switch matrix: a row reads low when a pressed key sits in the strobed column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
  end

  function automatic logic [3:0] col_exp(int s, int c0, int e);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << ((c0 + (e - s) / DW) % 4));
  endfunction

  // edge whose cycle is the last dwell cycle of column c and whose synchronized rows already see a press first present at edge p
  function automatic int detect(int c, int p);
    for (int e = p + 1; e < p + 200; e++)
      if ((e - scan_s) % DW == DW - 1 && (scan_c + (e - scan_s) / DW) % 4 == c) return e;
    return p + 200;
  endfunction

  function automatic logic is_pulse(int e, int v, int q);
`ifdef KEYPAD_REPEAT_EN
    return e >= v && (e - v) % RW == 0 && e <= q + 1;
`else
    return e == v && q > v;
`endif
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({key_valid, key_down, key_code, col} !== 10'b0_0_0000_1110)
      $display("FAIL reset: v/d/code/col=%b/%b/%h/%b want 0/0/0/1110", key_valid, key_down, key_code, col);
    if ({key_valid, key_down, key_code, col} !== 10'b0_0_0000_1110) errors++;
    reset = 1'b0;
    scan_s = cyc;
    scan_c = 0;
    repeat (32) begin
      @(negedge clk);
      checks++;
      if ({key_valid, key_down, key_code, col} !== {6'b0, col_exp(scan_s, 0, cyc)}) begin
        errors++;
        $display("FAIL idle_scan cyc=%0d: v/d/code/col=%b/%b/%h/%b want 0/0/0/%b", cyc, key_valid, key_down, key_code, col, col_exp(scan_s, 0, cyc));
      end
    end
  endtask

  task automatic test_press(input int r, input int c, input int hold, input logic [15:0] extra);
    int d, v, q, fin, w;
    logic [3:0] code, ecode, ecol, cc;
    logic ev, ed;
    w = r;
    for (int i = 3; i >= 0; i--) if (i == r || extra[i*4+c]) w = i;
    code = 4'(w * 4 + c);
    cc = ~(4'b0001 << c);
    @(negedge clk);
    keys = extra | (16'h1 << (r * 4 + c));
    d = detect(c, cyc + 1);
    v = d + 1 + DBW;
    q = v + hold + 1;
    fin = q + 2 + DBW;
    while (cyc < fin + 2) begin
      @(negedge clk);
      ev = is_pulse(cyc, v, q);
      ed = cyc >= v && cyc < fin;
      ecode = cyc >= v ? code : prev_code;
      ecol = cyc <= d ? col_exp(scan_s, scan_c, cyc) : cyc < fin ? cc : col_exp(fin, (c + 1) % 4, cyc);
      checks++;
      if ({key_valid, key_down, key_code, col} !== {ev, ed, ecode, ecol}) begin
        errors++;
        $display("FAIL press r%0d c%0d cyc=%0d: v/d/code/col=%b/%b/%h/%b want %b/%b/%h/%b", r, c, cyc, key_valid, key_down, key_code, col, ev, ed, ecode, ecol);
      end
      if (cyc == v + hold) keys = (extra | (16'h1 << (r * 4 + c))) & ~(16'h1 << (w * 4 + c));
    end
    keys = '0;
    prev_code = code;
    scan_s = fin;
    scan_c = (c + 1) % 4;
  endtask

  task automatic test_single_key;
    test_press(2, 1, 40, '0);
  endtask

  task automatic test_bounce(input int c);
    int d, b;
    logic [3:0] ecol;
    @(negedge clk);
    keys = 16'h1 << c;
    d = detect(c, cyc + 1);
    b = d + 4;
    while (cyc < b + 8) begin
      @(negedge clk);
      ecol = cyc <= d ? col_exp(scan_s, scan_c, cyc) : cyc < b + 2 ? ~(4'b0001 << c) : col_exp(b + 2, c, cyc);
      checks++;
      if ({key_valid, key_down, key_code, col} !== {2'b00, prev_code, ecol}) begin
        errors++;
        $display("FAIL bounce c%0d cyc=%0d: v/d/code/col=%b/%b/%h/%b want 0/0/%h/%b", c, cyc, key_valid, key_down, key_code, col, prev_code, ecol);
      end
      if (cyc == d + 3) keys = '0;
    end
    scan_s = b + 2;
    scan_c = c;
  endtask

  task automatic test_multi;
    test_press(3, 2, 10, 16'h1 << (1 * 4 + 2));
  endtask

  task automatic test_repeat;
    test_press(3, 3, 100, '0);
  endtask

  task automatic test_reset_held(input int r, input int c);
    int d, v;
    logic [3:0] code;
    code = 4'(r * 4 + c);
    @(negedge clk);
    keys = 16'h1 << (r * 4 + c);
    d = detect(c, cyc + 1);
    v = d + 1 + DBW;
    while (cyc < v + 5) begin
      @(negedge clk);
      checks++;
      if ({key_valid, key_down, key_code} !== {cyc == v, cyc >= v, cyc >= v ? code : prev_code}) begin
        errors++;
        $display("FAIL held_before_reset cyc=%0d: v/d/code=%b/%b/%h want %b/%b/%h", cyc, key_valid, key_down, key_code, cyc == v, cyc >= v, cyc >= v ? code : prev_code);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({key_valid, key_down, key_code, col} !== 10'b0_0_0000_1110) begin
      errors++;
      $display("FAIL reset_in_held: v/d/code/col=%b/%b/%h/%b want 0/0/0/1110", key_valid, key_down, key_code, col);
    end
    reset = 1'b0;
    keys = '0;
    scan_s = cyc;
    scan_c = 0;
    prev_code = '0;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if ({key_valid, key_down, key_code, col} !== {6'b0, col_exp(scan_s, 0, cyc)}) begin
        errors++;
        $display("FAIL after_reset cyc=%0d: v/d/code/col=%b/%b/%h/%b want 0/0/0/%b", cyc, key_valid, key_down, key_code, col, col_exp(scan_s, 0, cyc));
      end
    end
  endtask

  task automatic test_random;
    int r, c, rr;
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 20)) begin
        @(negedge clk);
        checks++;
        if ({key_valid, key_down, key_code, col} !== {2'b00, prev_code, col_exp(scan_s, scan_c, cyc)}) begin
          errors++;
          $display("FAIL idle_gap cyc=%0d: v/d/code/col=%b/%b/%h/%b want 0/0/%h/%b", cyc, key_valid, key_down, key_code, col, prev_code, col_exp(scan_s, scan_c, cyc));
        end
      end
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      rr = $urandom_range(0, 3);
      test_press(r, c, $urandom_range(3, 70), $urandom_range(0, 1) ? 16'(16'h1 << (rr * 4 + c)) : 16'h0);
    end
  endtask

  initial begin
    test_reset;
    test_single_key;
    test_bounce($urandom_range(0, 3));
    test_multi;
    test_repeat;
    test_reset_held($urandom_range(0, 3), $urandom_range(0, 3));
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end
endmodule
